fb_fill_dma: RTL

Framebuffer fill engine: the SDRAM *writer* counterpart of the video controller's framebuffer reader. On a start strobe it writes a rectangle of identical 16-bit pixels into SDRAM through the same rd/wr/rdy/ack request port the arbiter exposes to its clients. It emits a one-cycle done strobe for the interrupt controller, which lets the CPU clear or paint framebuffer regions without per-pixel stores.

---
 rtl/fb_fill_pkg.sv | 29 ++
 rtl/fb_fill_dma_if.sv | 33 +++
 rtl/fb_fill_addr_gen.sv | 62 ++++++
 rtl/fb_fill_dma.sv | 117 +++++++++++
 4 files changed

// File: rtl/fb_fill_pkg.sv
// Shared types and widths for the framebuffer fill engine and the CSR glue
// that programs it.
package fb_fill_pkg;

  localparam int unsigned ADDR_BITS   = 24;
  localparam int unsigned DIM_BITS    = 11;
  localparam int unsigned STRIDE_BITS = 12;
  localparam int unsigned PIX_BITS    = 16;
  localparam int unsigned MASK_BITS   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fill_state_e;

  // Rectangle geometry as programmed by the CPU
  typedef struct packed {
    logic [ADDR_BITS-1:0]   base;
    logic [DIM_BITS-1:0]    width;
    logic [DIM_BITS-1:0]    height;
    logic [STRIDE_BITS-1:0] stride;
  } fill_geom_t;

  function automatic logic geom_empty(input fill_geom_t g);
    return (g.width == '0) || (g.height == '0);
  endfunction

endpackage

// File: rtl/fb_fill_dma_if.sv
// SDRAM arbiter client port (rd/wr/rdy/ack request handshake).
interface fb_fill_dma_if;
  import fb_fill_pkg::*;

  logic                 sdram_wr;
  logic                 sdram_rd;
  logic [ADDR_BITS-1:0] sdram_addr_x16;
  logic [PIX_BITS-1:0]  sdram_wdata;
  logic [MASK_BITS-1:0] sdram_wmask;
  logic                 sdram_rdy;
  logic                 sdram_ack;

  modport master (
    output sdram_wr,
    output sdram_rd,
    output sdram_addr_x16,
    output sdram_wdata,
    output sdram_wmask,
    input  sdram_rdy,
    input  sdram_ack
  );

  modport slave (
    input  sdram_wr,
    input  sdram_rd,
    input  sdram_addr_x16,
    input  sdram_wdata,
    input  sdram_wmask,
    output sdram_rdy,
    output sdram_ack
  );

endinterface

// File: rtl/fb_fill_addr_gen.sv
// Raster-order 2D address walker: x/y counters plus a running row base,
// stepping one pixel per advance strobe.
module fb_fill_addr_gen
  import fb_fill_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  fill_geom_t           geom_i,
  input  logic                 advance_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_c
);

  logic [DIM_BITS-1:0]    x_q;
  logic [DIM_BITS-1:0]    y_q;
  logic [DIM_BITS-1:0]    w_last_q;
  logic [DIM_BITS-1:0]    h_last_q;
  logic [STRIDE_BITS-1:0] stride_q;
  logic [ADDR_BITS-1:0]   row_q;
  logic [ADDR_BITS-1:0]   addr_q;

  logic                   row_end_c;
  logic [ADDR_BITS-1:0]   row_next_c;

  assign row_end_c  = (x_q == w_last_q);
  assign row_next_c = row_q + ADDR_BITS'(stride_q);
  assign last_c     = row_end_c && (y_q == h_last_q);
  assign addr_o     = addr_q;

  // addr_q tracks row_q + x_q incrementally so no adder sits on the output
  always_ff @(posedge clk_i) begin : walk_regs
    if (rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      w_last_q <= '0;
      h_last_q <= '0;
      stride_q <= '0;
      row_q    <= '0;
      addr_q   <= '0;
    end else if (load_i) begin
      x_q      <= '0;
      y_q      <= '0;
      w_last_q <= geom_i.width - DIM_BITS'(1);
      h_last_q <= geom_i.height - DIM_BITS'(1);
      stride_q <= geom_i.stride;
      row_q    <= geom_i.base;
      addr_q   <= geom_i.base;
    end else if (advance_i) begin
      if (row_end_c) begin
        x_q    <= '0;
        y_q    <= y_q + DIM_BITS'(1);
        row_q  <= row_next_c;
        addr_q <= row_next_c;
      end else begin
        x_q    <= x_q + DIM_BITS'(1);
        addr_q <= addr_q + ADDR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/fb_fill_dma.sv
// Framebuffer fill engine: writes a rectangle of one 16-bit colour into SDRAM
// through the arbiter client port and pulses done_o when finished or aborted.
module fb_fill_dma
  import fb_fill_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_BITS-1:0]   base_i,
  input  logic [DIM_BITS-1:0]    width_i,
  input  logic [DIM_BITS-1:0]    height_i,
  input  logic [STRIDE_BITS-1:0] stride_i,
  input  logic [PIX_BITS-1:0]    color_i,
  input  logic                   abort_i,
  fb_fill_dma_if.master          sdram,
  output logic                   busy_o,
  output logic                   done_o
);

  fill_state_e          state_q;
  fill_state_e          state_d;

  logic                 hold_q;
  logic                 abort_q;
  logic                 busy_q;
  logic                 done_q;
  logic [PIX_BITS-1:0]  wdata_q;

  fill_geom_t           geom_c;
  logic                 load_c;
  logic                 wr_c;
  logic                 acked_c;
  logic                 last_c;
  logic [ADDR_BITS-1:0] addr_c;

  assign geom_c = '{base: base_i, width: width_i, height: height_i, stride: stride_i};

  // A raised request stays up until acked, whatever rdy does meanwhile
  assign wr_c    = (state_q == WRITE) && (hold_q || sdram.sdram_rdy);
  assign acked_c = wr_c && sdram.sdram_ack;

  fb_fill_addr_gen u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load_c),
    .geom_i    (geom_c),
    .advance_i (acked_c),
    .addr_o    (addr_c),
    .last_c    (last_c)
  );

  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort_q can only be set while a request is held, so it never needs to
  // be consulted when wr_c is low
  always_comb begin : next_state
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_c  = 1'b1;
          state_d = geom_empty(geom_c) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (acked_c) begin
          if (last_c || abort_q || abort_i) begin
            state_d = DONE;
          end
        end else if (!wr_c && abort_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin : ctrl_regs
    if (rst_i) begin
      hold_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      hold_q  <= wr_c && !sdram.sdram_ack;
      abort_q <= (state_q == WRITE) && (state_d == WRITE) && (abort_q || abort_i);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (load_c) begin
        wdata_q <= color_i;
      end
    end
  end

  assign sdram.sdram_wr       = wr_c;
  assign sdram.sdram_rd       = 1'b0;
  assign sdram.sdram_addr_x16 = addr_c;
  assign sdram.sdram_wdata    = wdata_q;
  assign sdram.sdram_wmask    = {MASK_BITS{wr_c}};

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
